// File: rtl/div_sched_pkg.sv
// Purpose: shared types and constants for the divider request scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package div_sched_pkg;

    localparam int DATA_W = 8;

    // Scheduler FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_e;

    // Operand pair as stored in the request FIFO (tag is packed alongside,
    // outside this struct, because its width is a top-level parameter).
    typedef struct packed {
        logic [DATA_W-1:0] dividend;
        logic [DATA_W-1:0] divisor;
    } operands_t;

endpackage

// File: rtl/div_req_fifo.sv
// Purpose: synchronous request FIFO (power-of-two depth) feeding the scheduler.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: full_o blocks pushes (even with a same-cycle pop); pop on empty is ignored.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i/push_dat_i  write request and data
//   pop_i/pop_dat_o    read request and head-of-queue data (combinational)
//   full_o, empty_o    status flags
//   count_o            number of stored entries (0..DEPTH)
module div_req_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               pop_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Push is qualified by the registered full flag, so a pop in the same
    // cycle never frees room for a push while full.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are AW bits wide, so increment wraps modulo DEPTH.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/div_request_scheduler.sv
// Purpose: streams buffered (dividend, divisor, tag) requests through a single-shot divider.
// Latency: out_valid 3 cycles + divider latency after a request reaches an empty, idle scheduler.
// Backpressure: in_ready = !fifo_full; while a result waits for out_ready nothing new is issued.
//
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   in_valid/in_ready/in_*           request stream (dividend, divisor, tag)
//   div_start/div_dividend/divisor   start pulse and held operands to the divider
//   div_done/error/quotient/remainder divider result (done is a level; its rising edge completes)
//   out_valid/out_ready/out_*        result stream (quotient, remainder, error, tag)
//   busy, occupancy                  FSM-not-idle flag and FIFO entry count
// Build option: define DIV_TIMEOUT_EN to force an error result after TIMEOUT
//   cycles in WAIT with no done edge; undefined, WAIT waits forever.
module div_request_scheduler
    import div_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_dividend,
    input  logic [DATA_W-1:0]       in_divisor,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    div_start,
    output logic [DATA_W-1:0]       div_dividend,
    output logic [DATA_W-1:0]       div_divisor,
    input  logic                    div_done,
    input  logic                    div_error,
    input  logic [DATA_W-1:0]       div_quotient,
    input  logic [DATA_W-1:0]       div_remainder,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_quotient,
    output logic [DATA_W-1:0]       out_remainder,
    output logic                    out_error,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int ENTRY_W = 2 * DATA_W + TAG_W;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] dividend_q, dividend_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] res_quo_q, res_quo_d;
    logic [DATA_W-1:0] res_rem_q, res_rem_d;
    logic              res_err_q, res_err_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
    logic              done_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    operands_t          head_ops;
    logic [TAG_W-1:0]   head_tag;
    logic               done_rise;
    logic               tmo_hit;

    div_req_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (reset),
        .push_i     (in_valid),
        .push_dat_i ({in_tag, in_dividend, in_divisor}),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (occupancy)
    );

    assign {head_tag, head_ops} = fifo_head;

    // The divider holds done high until the next start, so only a rising
    // edge marks a new completion.
    assign done_rise = div_done & ~done_q;

`ifdef DIV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // Counts WAIT cycles from 0; hitting TIMEOUT-1 means the transition to
    // OUTPUT lands exactly TIMEOUT cycles after WAIT was entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign tmo_hit = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        tag_d      = tag_q;
        res_quo_d  = res_quo_q;
        res_rem_d  = res_rem_q;
        res_err_d  = res_err_q;
        res_tag_d  = res_tag_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    dividend_d = head_ops.dividend;
                    divisor_d  = head_ops.divisor;
                    tag_d      = head_tag;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A real completion takes priority over a same-cycle timeout.
                if (done_rise) begin
                    res_err_d = div_error;
                    res_quo_d = div_error ? '0 : div_quotient;
                    res_rem_d = div_error ? '0 : div_remainder;
                    res_tag_d = tag_q;
                    state_d   = ST_OUTPUT;
                end else if (tmo_hit) begin
                    res_err_d = 1'b1;
                    res_quo_d = '0;
                    res_rem_d = '0;
                    res_tag_d = tag_q;
                    state_d   = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            tag_q      <= '0;
            res_quo_q  <= '0;
            res_rem_q  <= '0;
            res_err_q  <= 1'b0;
            res_tag_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            tag_q      <= tag_d;
            res_quo_q  <= res_quo_d;
            res_rem_q  <= res_rem_d;
            res_err_q  <= res_err_d;
            res_tag_q  <= res_tag_d;
            done_q     <= div_done;
        end
    end

    assign in_ready      = ~fifo_full;
    assign div_start     = (state_q == ST_ISSUE);
    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign out_valid     = (state_q == ST_OUTPUT);
    assign out_quotient  = res_quo_q;
    assign out_remainder = res_rem_q;
    assign out_error     = res_err_q;
    assign out_tag       = res_tag_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
